// File: rtl/fe_mul_arbiter_if.sv
// Operand/result bus between the arbiter and the shared field multiplier.
// The arbiter drives operands and the start pulse; the multiplier returns the product.
interface fe_mul_arbiter_if #(
    parameter int WIDTH = 320
);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             valid;
    logic [WIDTH-1:0] res;
    logic             done;

    modport master (
        output op_a,
        output op_b,
        output valid,
        input  res,
        input  done
    );

    modport slave (
        input  op_a,
        input  op_b,
        input  valid,
        output res,
        output done
    );
endinterface

// File: rtl/fe_mul_arbiter.sv
// Two-client round-robin scheduler in front of the shared field multiplier.
// Only one multiplication is in flight at a time. A watchdog aborts a launch
// that never completes and raises a sticky error flag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no operation; arbitrate pending requests
// ISSUE  | start pulse to multiplier, watchdog cleared
// WAIT   | waiting for mul_done, watchdog counting
// DONE   | result registered; done pulse to the owner, grant released
module fe_mul_arbiter #(
    parameter int WIDTH   = 320,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_i,
    input  logic [WIDTH-1:0] op_a0_i,
    input  logic [WIDTH-1:0] op_b0_i,
    output logic             gnt0_o,
    output logic             done0_o,

    input  logic             req1_i,
    input  logic [WIDTH-1:0] op_a1_i,
    input  logic [WIDTH-1:0] op_b1_i,
    output logic             gnt1_o,
    output logic             done1_o,

    output logic [WIDTH-1:0] res_o,
    output logic             err_o,
    output logic             busy_o,

    fe_mul_arbiter_if.master mul
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Abort fires when the incremented count reaches this value, so the
    // DONE state lands exactly TIMEOUT cycles after ISSUE.
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             last_gnt_q, last_gnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [CW-1:0]    wd_q, wd_d;
    logic             pick1;

    // Round-robin pick: client 1 wins when it is alone or when client 0 was served last.
    always_comb begin
        pick1 = req1_i && (!req0_i || (last_gnt_q == 1'b0));
    end

    // State register and datapath registers; reset puts client 1 as last served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            last_gnt_q <= 1'b1;
            err_q      <= 1'b0;
            res_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
            res_q      <= res_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            wd_q       <= wd_d;
        end
    end

    // Next-state and register updates; mul_done outside WAIT is deliberately ignored.
    always_comb begin
        state_d    = state_q;
        gnt0_d     = gnt0_q;
        gnt1_d     = gnt1_q;
        last_gnt_d = last_gnt_q;
        err_d      = err_q;
        res_d      = res_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        wd_d       = wd_q;

        case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    state_d    = S_ISSUE;
                    gnt0_d     = !pick1;
                    gnt1_d     = pick1;
                    last_gnt_d = pick1;
                    op_a_d     = pick1 ? op_a1_i : op_a0_i;
                    op_b_d     = pick1 ? op_b1_i : op_b0_i;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul.done) begin
                    res_d   = mul.res;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == WD_LAST) begin
                        err_d   = 1'b1;
                        res_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mul.op_a  = op_a_q;
    assign mul.op_b  = op_b_q;
    assign mul.valid = (state_q == S_ISSUE);

    assign gnt0_o  = gnt0_q;
    assign gnt1_o  = gnt1_q;
    assign done0_o = (state_q == S_DONE) && gnt0_q;
    assign done1_o = (state_q == S_DONE) && gnt1_q;
    assign res_o   = res_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// Directed bench for fe_mul_arbiter with a latency-programmable multiplier model
// and a scoreboard of expected (client, result) pairs.
module tb_fe_mul_arbiter;
    localparam int WIDTH   = 320;
    localparam int TIMEOUT = 8;
    localparam int CW      = 4;

    typedef logic [WIDTH-1:0] word_t;
    typedef struct {
        logic  client;
        word_t res;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  req0, req1;
    word_t op_a0, op_b0, op_a1, op_b1;
    logic  gnt0, gnt1, done0, done1, err, busy;
    word_t res;

    logic  m_done, f_done, mul_auto;
    word_t m_res, f_res, prod;
    int    mul_lat;

    int    total = 0;
    int    bad   = 0;
    exp_t  sb[$];

    fe_mul_arbiter_if #(.WIDTH(WIDTH)) mul_if ();

    assign mul_if.done = m_done | f_done;
    assign mul_if.res  = f_done ? f_res : m_res;

    fe_mul_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0_i  (req0),
        .op_a0_i (op_a0),
        .op_b0_i (op_b0),
        .gnt0_o  (gnt0),
        .done0_o (done0),
        .req1_i  (req1),
        .op_a1_i (op_a1),
        .op_b1_i (op_b1),
        .gnt1_o  (gnt1),
        .done1_o (done1),
        .res_o   (res),
        .err_o   (err),
        .busy_o  (busy),
        .mul     (mul_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic c, input word_t v);
        exp_t e;
        e.client = c;
        e.res    = v;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mul_if.valid && n < max);
        chk("valid_seen", word_t'(mul_if.valid), 1);
    endtask

    task automatic wait_done(input logic c, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(c ? done1 : done0) && n < max);
        chk("done_seen", word_t'(c ? done1 : done0), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_res", res, 0);
        chk("rst_err", word_t'(err), 0);
        chk("rst_busy", word_t'(busy), 0);
        chk("rst_gnt", word_t'({gnt1, gnt0}), 0);
        chk("rst_done", word_t'({done1, done0}), 0);
        chk("rst_valid", word_t'(mul_if.valid), 0);
        chk("rst_op_a", mul_if.op_a, 0);
        chk("rst_op_b", mul_if.op_b, 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Multiplier model: sees the start pulse, returns the product mul_lat cycles later.
    initial begin
        m_done = 1'b0;
        m_res  = '0;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (mul_if.valid && mul_auto) begin
                prod = mul_if.op_a * mul_if.op_b;
                repeat (mul_lat) @(negedge clk);
                m_done = 1'b1;
                m_res  = prod;
            end
        end
    end

    // Scoreboard monitor and per-cycle grant/done invariants.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("gnt_excl", word_t'(gnt0 & gnt1), 0);
            chk("done0_owner", word_t'(done0 & !gnt0), 0);
            chk("done1_owner", word_t'(done1 & !gnt1), 0);
            if (done0 || done1) begin
                chk("sb_expected", word_t'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_client", word_t'(done1), word_t'(e.client));
                    chk("done_res", res, e.res);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        req0 = 1'b0; req1 = 1'b0;
        op_a0 = '0; op_b0 = '0; op_a1 = '0; op_b1 = '0;
        f_done = 1'b0; f_res = '0;
        mul_auto = 1'b1; mul_lat = 3;

        do_reset();

        // Single request, latency 3
        op_a0 = 3; op_b0 = 5; req0 = 1'b1;
        exp_push(1'b0, 15);
        wait_valid(5, n);
        chk("t1_issue_lat", n, 1);
        chk("t1_op_a", mul_if.op_a, 3);
        chk("t1_op_b", mul_if.op_b, 5);
        chk("t1_gnt0", word_t'(gnt0), 1);
        chk("t1_gnt1", word_t'(gnt1), 0);
        wait_done(1'b0, 20, n);
        chk("t1_done_lat", n, 4);
        req0 = 1'b0;
        @(negedge clk);
        chk("t1_busy_after", word_t'(busy), 0);
        chk("t1_gnt0_after", word_t'(gnt0), 0);

        // Simultaneous requests after reset: 0,1,0,1
        do_reset();
        mul_lat = 2;
        op_a0 = 2; op_b0 = 3; op_a1 = 4; op_b1 = 5;
        exp_push(1'b0, 6);
        exp_push(1'b1, 20);
        exp_push(1'b0, 6);
        exp_push(1'b1, 20);
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(8, n);
            chk("t2_gap", n, (i == 0) ? 1 : 2);
            chk("t2_gnt0", word_t'(gnt0), word_t'(i % 2 == 0));
            chk("t2_op_a", mul_if.op_a, (i % 2 == 0) ? 2 : 4);
            wait_done(logic'(i % 2), 20, n);
            chk("t2_done_lat", n, 3);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("t2_busy_after", word_t'(busy), 0);

        // Back-to-back single client, latency 1
        mul_lat = 1;
        op_a1 = 7; op_b1 = 9; req1 = 1'b1;
        exp_push(1'b1, 63);
        wait_valid(5, n);
        chk("t3_issue_lat", n, 1);
        wait_done(1'b1, 10, n);
        chk("t3_done_lat_a", n, 2);
        op_a1 = 2; op_b1 = 4;
        exp_push(1'b1, 8);
        begin
            int m;
            wait_valid(8, m);
            chk("t3_valid_spacing", n + m, 4);
        end
        chk("t3_op_a2", mul_if.op_a, 2);
        wait_done(1'b1, 10, n);
        chk("t3_done_lat_b", n, 2);
        req1 = 1'b0;
        @(negedge clk);

        // Watchdog: multiplier never answers
        mul_auto = 1'b0;
        op_a0 = 3; op_b0 = 5; req0 = 1'b1;
        exp_push(1'b0, 0);
        wait_valid(5, n);
        wait_done(1'b0, 30, n);
        chk("t4_wd_lat", n, TIMEOUT);
        chk("t4_err", word_t'(err), 1);
        req0 = 1'b0;
        mul_auto = 1'b1; mul_lat = 2;
        @(negedge clk);
        op_a0 = 6; op_b0 = 7; req0 = 1'b1;
        exp_push(1'b0, 42);
        wait_valid(5, n);
        wait_done(1'b0, 20, n);
        chk("t4_err_sticky", word_t'(err), 1);
        req0 = 1'b0;
        @(negedge clk);
        do_reset();

        // Stray done in IDLE
        mul_auto = 1'b0;
        f_res = 99; f_done = 1'b1;
        @(negedge clk);
        f_done = 1'b0;
        chk("t5_stray_busy", word_t'(busy), 0);
        chk("t5_stray_err", word_t'(err), 0);
        chk("t5_stray_res", res, 0);
        chk("t5_stray_gnt", word_t'({gnt1, gnt0}), 0);

        // Reset during WAIT, late done afterwards
        op_a0 = 3; op_b0 = 5; req0 = 1'b1;
        wait_valid(5, n);
        @(negedge clk);
        chk("t5_in_wait", word_t'(busy), 1);
        rst = 1'b1; req0 = 1'b0;
        #1;
        chk("t5_rst_gnt", word_t'({gnt1, gnt0}), 0);
        chk("t5_rst_busy", word_t'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        f_res = 77; f_done = 1'b1;
        @(negedge clk);
        f_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_late_res", res, 0);
            chk("t5_late_err", word_t'(err), 0);
            chk("t5_late_busy", word_t'(busy), 0);
            chk("t5_late_done", word_t'({done1, done0}), 0);
            @(negedge clk);
        end

        // Operand change after grant has no effect
        mul_auto = 1'b1; mul_lat = 2;
        op_a0 = 3; op_b0 = 5; req0 = 1'b1;
        exp_push(1'b0, 15);
        wait_valid(5, n);
        @(negedge clk);
        op_a0 = 11;
        @(negedge clk);
        chk("t6_op_a_held", mul_if.op_a, 3);
        wait_done(1'b0, 10, n);
        chk("t6_res", res, 15);
        req0 = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fe_mul_arbiter.md
Name: fe_mul_arbiter

Overview:
- Two-client arbiter that sits directly upstream of the shared field multiplier (fe_mulx) inside the EPU.
- Accepts operand requests from two point-arithmetic sequencers (client 0 = double-scalar-mult, client 1 = final-normalise/invert). It grants them round-robin, launches one multiplication at a time and routes the result back to the requester.
- Replaces ad-hoc combinational muxing with a registered, handshaked, single-outstanding-operation scheduler, plus a watchdog on the multiplier.

Parameters:
- WIDTH, 320, operand/result width in bits.
- TIMEOUT, 1024, max cycles to wait for mul_done after launch before aborting (must be >= 2).
- CW, 11, width of the watchdog counter (must hold TIMEOUT).

Ports:
- clk  in  1  module clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  client 0 request; held high with stable operands until done0.
- op_a0  in  WIDTH  client 0 operand A.
- op_b0  in  WIDTH  client 0 operand B.
- gnt0  out  1  high while client 0 owns the multiplier.
- done0  out  1  one-cycle pulse: res is valid for client 0.
- req1, op_a1, op_b1, gnt1, done1: same as client 0, for client 1.
- res  out  WIDTH  registered product of the last completed operation.
- err  out  1  sticky watchdog flag; cleared only by rst.
- busy  out  1  high in any state other than IDLE.
- mul_op_a  out  WIDTH  latched operand A to the multiplier.
- mul_op_b  out  WIDTH  latched operand B to the multiplier.
- mul_valid  out  1  one-cycle start pulse to the multiplier.
- mul_res  in  WIDTH  multiplier result, valid when mul_done is high.
- mul_done  in  1  multiplier completion pulse.

Behaviour:
- Reset (async, immediate): every output is 0, state = IDLE, last_gnt = 1 (client 0 wins the first tie), watchdog = 0.
- The FSM is registered and has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If exactly one req is high, grant that client.
  - If both are high, grant the client not equal to last_gnt.
  - On a grant: latch its op_a/op_b into mul_op_a/mul_op_b, set gnt_i, set last_gnt = i, go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE: mul_valid = 1 for exactly this cycle; watchdog cleared; go to WAIT.
- WAIT:
  - If mul_done = 1: res <= mul_res, go to DONE.
  - Otherwise increment the watchdog. When it reaches TIMEOUT-1: err <= 1, res <= 0, go to DONE (the requester still receives done_i).
- DONE:
  - done_i = 1 for exactly this cycle, gnt_i drops at the end of the cycle, go to IDLE.
  - req is not sampled in DONE.
- Outputs:
  - gnt_i is high from ISSUE through DONE inclusive.
  - gnt0 and gnt1 are never high together.
  - done_i pulses only to the granted client.
- Latency:
  - If req is first sampled high in IDLE at cycle n: mul_valid is high in cycle n+1.
  - With mul_done at n+1+L (L >= 1), done_i is high at n+2+L.
  - Minimum request-to-done time is 4 cycles.
- Client protocol:
  - A client drops req on the same edge it samples done_i = 1.
  - A req still high in the following IDLE cycle is treated as a new request. This supports back-to-back operations, and round-robin still applies.
- mul_done arriving in IDLE, ISSUE or DONE is ignored (it does not change state or err). This covers stale completions after a reset.
- mul_op_a/mul_op_b hold their values from grant until the next grant. They are not cleared in DONE.
- Operand changes by a client after its grant have no effect.
- A req deasserted while its operation is in flight does not abort the operation; done_i is still pulsed.
- Reset mid-operation: the in-flight result is discarded and the FSM returns to IDLE. No done pulse is produced.
- Widths: res and the mul ports are exactly WIDTH bits; no arithmetic is performed on the operands.

Test Plan:
- Single request: req0 = 1, op_a0 = 3, op_b0 = 5, model multiplier L = 3 returning 15 -> mul_valid at cycle 1, mul_op_a = 3, mul_op_b = 5, done0 at cycle 5 with res = 15, gnt1/done1 stay 0, busy falls after DONE.
- Simultaneous requests after reset: req0 = req1 = 1 at cycle 0 -> client 0 is served first. Client 1 is granted in the IDLE cycle after done0. Issue order 0,1,0,1 over four back-to-back operations with both reqs held high.
- Back-to-back single client: req1 held high with operands 7/9 then 2/4 (L = 1) -> two mul_valid pulses 4 cycles apart, results 63 then 8 on consecutive done1 pulses.
- Watchdog: TIMEOUT = 8, multiplier never asserts done -> done0 exactly 8 cycles after ISSUE, res = 0, err = 1 and err stays 1 through further good operations until rst.
- Stray and late done: mul_done pulsed in IDLE -> no state change, err = 0. Assert rst during WAIT, then deliver mul_done after rst falls -> outputs are 0 and no done0/done1 pulse.
- Operand stability: change op_a0 from 3 to 11 one cycle after gnt0 rises -> mul_op_a stays 3 and res = 15.
